// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage elastic leading-zero count and left-normalise unit,
// with optional rounding of the shift down to even for square-root exponents.
module lzc_norm_pipe #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_even,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);
  logic             s1_valid, s1_even, s2_valid, s2_adv, zero;
  logic [WIDTH-1:0] s1_data, norm;
  logic [TAG_W-1:0] s1_tag;
  logic [CW-1:0]    lz, cnt;
  assign s2_adv = s1_valid & (!s2_valid | out_ready);
  assign in_ready = !s1_valid | s2_adv;
  assign out_valid = s2_valid;
  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) if (s1_data[i]) lz = CW'(WIDTH - 1 - i);
    zero = ~|s1_data;
    cnt = zero ? '0 : s1_even ? {lz[CW-1:1], 1'b0} : lz;
    norm = s1_data << cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_even <= 1'b0;
      s1_tag <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_data <= in_data;
      s1_even <= in_even;
      s1_tag <= in_tag;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_count <= '0;
      out_norm <= '0;
      out_zero <= 1'b0;
      out_tag <= '0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      out_count <= cnt;
      out_norm <= norm;
      out_zero <= zero;
      out_tag <= s1_tag;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb_lzc_norm_pipe: directed and random checks of lzc_norm_pipe against a
// scoreboard of expected results, including backpressure and async reset.
module tb_lzc_norm_pipe;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, in_even = 0, out_valid, out_ready = 1, out_zero;
  logic [23:0] in_data = '0, out_norm;
  logic [3:0]  in_tag = '0, out_tag;
  logic [4:0]  out_count;
  int          errors = 0, checks = 0, w, stalls;
  typedef struct packed {
    logic [4:0]  cnt;
    logic [23:0] norm;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb[$];
  exp_t mon_x;

  lzc_norm_pipe #(.WIDTH(24), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_even(in_even), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_norm(out_norm), .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [23:0] d, input logic e, input logic [3:0] t);
    exp_t x;
    int lz = 0;
    while (lz < 24 && d[23 - lz] == 1'b0) lz++;
    x.zero = (lz == 24);
    x.cnt = x.zero ? 5'd0 : 5'(e ? lz - (lz % 2) : lz);
    x.norm = d << x.cnt;
    x.tag = t;
    return x;
  endfunction

  task automatic sendx(input logic [23:0] d, input logic e, input logic [3:0] t,
                       input exp_t x, output int waits);
    bit done = 0;
    in_valid = 1; in_data = d; in_even = e; in_tag = t; waits = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(x);
        done = 1;
      end else if (++waits > 50) begin
        chk("accept_timeout", 0, 1);
        done = 1;
      end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send(input logic [23:0] d, input logic e, input logic [3:0] t, output int waits);
    sendx(d, e, t, model(d, e, t), waits);
  endtask

  function automatic exp_t mk(input logic [4:0] c, input logic [23:0] n, input logic z, input logic [3:0] t);
    return '{cnt: c, norm: n, zero: z, tag: t};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        mon_x = sb.pop_front();
        chk("count", out_count, mon_x.cnt);
        chk("norm", out_norm, mon_x.norm);
        chk("zero", out_zero, mon_x.zero);
        chk("tag", out_tag, mon_x.tag);
      end
    end
  end

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_norm", out_norm, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    sendx(24'h000100, 0, 4'h1, mk(15, 24'h800000, 0, 4'h1), w);
    @(negedge clk); chk("lat_early", out_valid, 0);
    @(negedge clk); chk("lat_ready", out_valid, 1);
    @(posedge clk); #1;
    sendx(24'h800000, 0, 4'h2, mk(0, 24'h800000, 0, 4'h2), w);
    sendx(24'h000001, 0, 4'h3, mk(23, 24'h800000, 0, 4'h3), w);
    sendx(24'h000100, 1, 4'h4, mk(14, 24'h400000, 0, 4'h4), w);
    sendx(24'h000001, 1, 4'h5, mk(22, 24'h400000, 0, 4'h5), w);
    sendx(24'h400000, 1, 4'h6, mk(0, 24'h400000, 0, 4'h6), w);
    sendx(24'h200000, 1, 4'h7, mk(2, 24'h800000, 0, 4'h7), w);
    sendx(24'h000000, 0, 4'hA, mk(0, 24'h000000, 1, 4'hA), w);
    sendx(24'h000000, 1, 4'hB, mk(0, 24'h000000, 1, 4'hB), w);
    repeat (3) @(posedge clk); #1;
    chk("directed_drain", sb.size(), 0);
    // Backpressure: two operands fill the pipe, the third must wait.
    out_ready = 0;
    sendx(24'h000100, 0, 4'h1, mk(15, 24'h800000, 0, 4'h1), w);
    send(24'h0A5A5A, 0, 4'h2, w);
    in_valid = 1; in_data = 24'h000777; in_even = 1; in_tag = 4'h3;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_tag", out_tag, 1);
      chk("bp_norm", out_norm, 24'h800000);
      chk("bp_count", out_count, 15);
    end
    @(posedge clk); #1;
    out_ready = 1;
    stalls = 0;
    send(24'h000777, 1, 4'h3, w); stalls += w;
    send(24'h012345, 0, 4'h4, w); stalls += w;
    send(24'h000003, 1, 4'h5, w); stalls += w;
    chk("bp_resume_stalls", stalls, 0);
    repeat (3) @(posedge clk); #1;
    chk("bp_drain", sb.size(), 0);
    // Full-throughput random stream.
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      send(24'($urandom >> $urandom_range(0, 31)), 1'($urandom_range(0, 1)), 4'(k), w);
      stalls += w;
    end
    chk("stream_stalls", stalls, 0);
    repeat (3) @(posedge clk); #1;
    chk("stream_drain", sb.size(), 0);
    // Asynchronous reset between edges with both stages full.
    out_ready = 0;
    send(24'h00F000, 0, 4'hC, w);
    send(24'h000F00, 1, 4'hD, w);
    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_norm", out_norm, 0);
    chk("mid_rst_zero", out_zero, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_ready", in_ready, 1);
    sb.delete();
    @(negedge clk); #1 rst = 0;
    @(posedge clk); #1;
    out_ready = 1;
    send(24'h000010, 0, 4'h9, w);
    repeat (4) @(posedge clk); #1;
    chk("post_rst_drain", sb.size(), 0);
    chk("post_rst_idle", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
